// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_if
// Purpose  : Bundle between a display requester and the multiplexed
//            7-segment scan controller.
// Signals  : en         - scan enable (requester -> controller)
//            value      - 4*NDIG hex digits, nibble 0 is the rightmost digit
//            load       - level request to capture value
//            ack        - one-cycle pulse, value captured this cycle
//            blank_mask - bit k=1 keeps digit k dark
//            zi         - nibble to the shared hex-to-7-segment decoder
//            an         - digit anodes, active-low
//            frame_done - one-cycle pulse at the end of each full scan
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_if #(
    parameter int NDIG = 4
);
    logic                en;
    logic [4*NDIG-1:0]   value;
    logic                load;
    logic                ack;
    logic [NDIG-1:0]     blank_mask;
    logic [3:0]          zi;
    logic [NDIG-1:0]     an;
    logic                frame_done;

    // Requester side
    modport master (
        output en, value, load, blank_mask,
        input  ack, zi, an, frame_done
    );

    // Scan controller side
    modport slave (
        input  en, value, load, blank_mask,
        output ack, zi, an, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for an NDIG-digit common-segment
//            7-segment display. Each digit is preceded by an all-dark gap of
//            BLANK_CYC cycles and then lit for ON_CYC cycles. The displayed
//            value lives in a shadow register that only updates at a frame
//            boundary or while idle, so a digit never tears mid-frame.
// Ports    : clk   - clock, all state on rising edge
//            rst_n - asynchronous active-low reset
//            bus   - seg_scan_if slave modport (en, value, load, ack,
//                    blank_mask, zi, an, frame_done)
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int ON_CYC    = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int C_MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int C_CNT_W   = (C_MAX_CYC > 1) ? $clog2(C_MAX_CYC) : 1;
    localparam int C_IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [C_CNT_W-1:0] C_BLANK_LAST = C_CNT_W'(BLANK_CYC - 1);
    localparam logic [C_CNT_W-1:0] C_ON_LAST    = C_CNT_W'(ON_CYC - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST   = C_IDX_W'(NDIG - 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                  state_q,  state_d;
    logic [C_IDX_W-1:0]      idx_q,    idx_d;
    logic [C_CNT_W-1:0]      cnt_q,    cnt_d;
    logic [NDIG-1:0][3:0]    shadow_q, shadow_d;
    logic [NDIG-1:0]         an_q,     an_d;
    logic [3:0]              zi_q,     zi_d;

    logic                    w_frame_done;
    logic                    w_ack;

    // ------------------------------------------------------------------
    // Next-state, shadow-load and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q + C_CNT_W'(1);
        shadow_d     = shadow_q;
        w_frame_done = 1'b0;
        w_ack        = 1'b0;

        case (state_q)
            S_OFF: begin
                idx_d = '0;
                cnt_d = '0;
                if (bus.en) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                if (cnt_q == C_BLANK_LAST) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                end
            end
            S_SHOW: begin
                if (cnt_q == C_ON_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    if (idx_q == C_IDX_LAST) begin
                        idx_d        = '0;
                        w_frame_done = 1'b1;
                    end else begin
                        idx_d = idx_q + C_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_OFF;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Disable wins over everything: the scan is dropped without a frame
        // boundary, so neither frame_done nor a boundary load can happen.
        if (!bus.en) begin
            state_d      = S_OFF;
            idx_d        = '0;
            cnt_d        = '0;
            w_frame_done = 1'b0;
        end

        // Capture only when idle or exactly on the frame boundary. ack is
        // qualified with rst_n because the state already reads OFF while
        // reset is held, and a load request then must not be acknowledged.
        w_ack = rst_n && bus.load && ((state_q == S_OFF) || w_frame_done);
        if (w_ack) begin
            shadow_d = bus.value;
        end

        // Outputs are registered from the next state so that an/zi line up
        // with the state they describe and never glitch.
        an_d = '1;
        if (state_d == S_SHOW) begin
            an_d[idx_d] = 1'b0;
        end
        zi_d = shadow_d[idx_d];
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_OFF;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            an_q     <= '1;
            zi_q     <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            zi_q     <= zi_d;
        end
    end

    // an_q has at most one low bit, so OR-ing the mask can only darken a
    // digit; the mask acts immediately and leaves scan timing untouched.
    assign bus.an         = an_q | bus.blank_mask;
    assign bus.zi         = zi_q;
    assign bus.ack        = w_ack;
    assign bus.frame_done = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl (NDIG=4, ON_CYC=4,
//            BLANK_CYC=2). The driver pushes the expected per-cycle outputs
//            into a scoreboard queue; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;
    localparam int NDIG      = 4;
    localparam int ON_CYC    = 4;
    localparam int BLANK_CYC = 2;
    localparam int SLOT      = BLANK_CYC + ON_CYC;   // 6 cycles per digit
    localparam int FRAME     = NDIG * SLOT;          // 24 cycles per frame

    logic clk;
    logic rst_n;

    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(
        .NDIG      (NDIG),
        .ON_CYC    (ON_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         pos;
        logic [3:0] an;
        logic [3:0] zi;
        logic       fd;
        logic       ack;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_x;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          pos;          // position in frame, -1 while idle
    logic [15:0] sh;           // expected shadow contents

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: compute what the outputs must be this cycle,
    // push it, drive the inputs, advance to just after the next edge.
    task automatic tick(input logic e, input logic ld, input logic [15:0] v, input logic [3:0] m);
        exp_t x;
        int   d;
        int   ph;
        x.pos = pos;
        if (pos < 0) begin
            x.an  = 4'hF;
            x.zi  = sh[3:0];
            x.fd  = 1'b0;
            x.ack = ld;
        end else begin
            d     = pos / SLOT;
            ph    = pos % SLOT;
            x.an  = (ph >= BLANK_CYC) ? (~(4'b0001 << d) | m) : 4'hF;
            x.zi  = sh[d*4 +: 4];
            x.fd  = e && (pos == FRAME - 1);
            x.ack = x.fd && ld;
        end
        bus.en         = e;
        bus.load       = ld;
        bus.value      = v;
        bus.blank_mask = m;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (x.ack) sh = v;
        if (!e)          pos = -1;
        else if (pos < 0) pos = 0;
        else             pos = (pos + 1) % FRAME;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_x = sb.pop_front();
            check_val($sformatf("an@%0d",  mon_x.pos), 32'(bus.an),         32'(mon_x.an));
            check_val($sformatf("zi@%0d",  mon_x.pos), 32'(bus.zi),         32'(mon_x.zi));
            check_val($sformatf("fd@%0d",  mon_x.pos), 32'(bus.frame_done), 32'(mon_x.fd));
            check_val($sformatf("ack@%0d", mon_x.pos), 32'(bus.ack),        32'(mon_x.ack));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.load       = 1'b1;
        bus.value      = 16'h1A2F;
        bus.blank_mask = 4'h0;
        pos            = -1;
        sh             = 16'h0;

        // Reset state, with a load request already pending
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_an",  32'(bus.an),         32'hF);
        check_val("rst_zi",  32'(bus.zi),         32'h0);
        check_val("rst_ack", 32'(bus.ack),        32'h0);
        check_val("rst_fd",  32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;

        // Power-up load while idle, then zi shows nibble 0 (F)
        tick(1'b0, 1'b1, 16'h1A2F, 4'h0);
        tick(1'b0, 1'b0, 16'h0, 4'h0);

        // Scan order over two frames
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        repeat (2 * FRAME) tick(1'b1, 1'b0, 16'h0, 4'h0);

        // Tear-free update: request mid-frame, held until the boundary ack
        repeat (10) tick(1'b1, 1'b0, 16'h0, 4'h0);
        do tick(1'b1, 1'b1, 16'h5555, 4'h0); while (pos != 0);
        repeat (FRAME) tick(1'b1, 1'b0, 16'h0, 4'h0);

        // Digit 2 masked for a frame
        repeat (FRAME) tick(1'b1, 1'b0, 16'h0, 4'b0100);

        // Abandoned request: load for 3 cycles mid-frame then dropped
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b1, (i >= 3 && i < 6), 16'h9999, 4'h0);
        end

        // Disable during SHOW of digit 2, then restart from digit 0
        while (pos != 15) tick(1'b1, 1'b0, 16'h0, 4'h0);
        tick(1'b0, 1'b0, 16'h0, 4'h0);
        tick(1'b0, 1'b0, 16'h0, 4'h0);
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        while (pos != FRAME - 1) tick(1'b1, 1'b0, 16'h0, 4'h0);

        // Disable exactly on the last cycle: no frame_done and no ack,
        // the still-held request is then accepted while idle
        tick(1'b0, 1'b1, 16'hABCD, 4'h0);
        tick(1'b0, 1'b1, 16'hABCD, 4'h0);
        tick(1'b0, 1'b0, 16'h0, 4'h0);
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        while (pos != 3) tick(1'b1, 1'b0, 16'h0, 4'h0);

        // Asynchronous reset pulse between edges while digit 0 is lit
        bus.en    = 1'b0;
        bus.load  = 1'b1;
        bus.value = 16'hBEEF;
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_an",  32'(bus.an),         32'hF);
        check_val("arst_zi",  32'(bus.zi),         32'h0);
        check_val("arst_ack", 32'(bus.ack),        32'h0);
        check_val("arst_fd",  32'(bus.frame_done), 32'h0);
        #1 rst_n = 1'b1;
        bus.load = 1'b0;
        @(posedge clk);
        #1;
        pos = -1;
        sh  = 16'h0;

        // Shadow must read back as zero on every digit
        tick(1'b0, 1'b0, 16'h0, 4'h0);
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        repeat (FRAME) tick(1'b1, 1'b0, 16'h0, 4'h0);

        @(negedge clk);
        #1;
        check_val("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameters SHALL be:
- NDIG, default 4: number of display digits.
- ON_CYC, default 50000: clock cycles each digit anode is lit.
- BLANK_CYC, default 16: clock cycles all anodes are off before each digit (ghost suppression).

REQ-002 Ports SHALL be:
- clk  in  1: single clock; all state on rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- en  in  1: scan enable.
- value  in  4*NDIG: hex digits; nibble k feeds digit k, nibble 0 is rightmost.
- load  in  1: level request to update the display value.
- ack  out  1: one-cycle pulse; value was captured this cycle.
- blank_mask  in  NDIG: bit k=1 keeps digit k dark.
- zi  out  4: nibble to the shared hex-to-7-segment decoder.
- an  out  NDIG: anodes, active-low.
- frame_done  out  1: one-cycle pulse at the end of each full scan.

REQ-003 The block SHALL be the only driver of the shared decoder input. The decoder output SHALL drive the segment lines of all digits in common.

Function
REQ-004 The FSM SHALL have states OFF, BLANK and SHOW, a digit index idx (0..NDIG-1), and one cycle counter cnt.
REQ-005 cnt SHALL be clog2(max(ON_CYC, BLANK_CYC)) bits wide. It SHALL clear on every state change.
REQ-006 In OFF:
- an SHALL be all ones.
- idx and cnt SHALL be 0.
- When en=1, the FSM SHALL go to BLANK on the next edge.
REQ-007 In BLANK:
- an SHALL be all ones.
- zi SHALL equal shadow nibble idx.
- After BLANK_CYC cycles in BLANK, the FSM SHALL go to SHOW.
REQ-008 In SHOW:
- zi SHALL equal shadow nibble idx.
- an[idx] SHALL be 0 unless blank_mask[idx]=1. All other an bits SHALL be 1.
- After ON_CYC cycles in SHOW, the FSM SHALL go to BLANK.
REQ-009 On the SHOW->BLANK transition, idx SHALL increment. If idx=NDIG-1, idx SHALL wrap to 0 and frame_done SHALL pulse for one cycle.
REQ-010 The display value SHALL be held in an internal shadow register, 4*NDIG bits. Only the shadow register SHALL drive zi.
REQ-011 The shadow register SHALL load from value only when load=1 at one of these two points, so that digits never tear mid-frame:
- the frame boundary (the cycle frame_done pulses);
- any cycle in state OFF.
REQ-012 ack SHALL pulse high for exactly the cycle in which the shadow register loads. No ack SHALL occur otherwise.
REQ-013 The requester SHALL hold value stable while load=1. It SHALL drop load the cycle after ack.
- If load stays high, the block SHALL reload at the next frame boundary and pulse ack again.
- If load drops before a boundary, the request SHALL be abandoned and no ack SHALL be issued.
REQ-014 en=0 in any state SHALL force OFF on the next edge. It SHALL produce no frame_done. The shadow register SHALL be retained.
REQ-015 blank_mask changes SHALL take effect combinationally on an. They SHALL not alter FSM timing.
REQ-016 One frame SHALL last exactly NDIG*(BLANK_CYC+ON_CYC) cycles from BLANK entry with idx=0.
REQ-017 an SHALL never have more than one bit low in any cycle.
REQ-018 an and zi SHALL be registered outputs, glitch-free.

Reset
REQ-019 While rst_n=0, regardless of clk, the following SHALL hold:
- state=OFF, idx=0, cnt=0;
- shadow register = 0, zi=0;
- an all ones;
- ack=0, frame_done=0.
REQ-020 After rst_n deasserts, the FSM SHALL leave OFF no earlier than the first rising edge at which en=1 is sampled.
REQ-021 Reset asserted mid-frame SHALL abort the scan immediately. The shadow register SHALL return to 0, and any pending load SHALL be discarded without ack.

Verification
Bench parameters: NDIG=4, ON_CYC=4, BLANK_CYC=2.
REQ-022 Power-up load: rst_n low, then high; en=0; value=16'h1A2F; load=1 -> ack pulses on the first edge; zi=0 afterwards is not required because idx=0 gives zi=4'hF; an stays 4'b1111.
REQ-023 Scan order: en=1 -> an sequence per frame is 1111 x2, 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011 x4, 1111 x2, 0111 x4. zi during the lit cycles is F, 2, A, 1. frame_done pulses every 24 cycles.
REQ-024 Tear-free update: mid-frame, value=16'h5555 and load=1 -> zi unchanged until the boundary; ack and frame_done pulse in the same cycle; the next frame shows 5,5,5,5.
REQ-025 Blanking and abandon: blank_mask=4'b0100 -> an[2] is never low and the timing is identical. Separately, load=1 for 3 cycles mid-frame and then dropped -> no ack and the shadow register is unchanged.
REQ-026 Disable and reset: en=0 during SHOW of idx=2 -> the next edge gives an=1111 and idx=0; re-enable -> scan restarts at digit 0. rst_n=0 pulsed asynchronously between edges -> an=1111 and zi=0 immediately; shadow register = 0.
